// File: rtl/wb_analog_ctrl.sv
// Wishbone register bank for the analog user project: GPIO drive, input
// synchronisation, edge counting on one selected input and a threshold interrupt.
module wb_analog_ctrl #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          NIO      = 27,
  parameter int          CNT_W    = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [NIO-1:0]   io_in,
  output logic [NIO-1:0]   io_out,
  output logic [NIO-1:0]   io_oeb,
  output logic [2:0]       irq
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             hit, req, ack, wr, clr, w1c, edge_det, pend_set;
  logic             pnd_we, en, irq_en, pend;
  logic [5:0]       pnd_off;
  logic [3:0]       pnd_sel;
  logic [31:0]      pnd_dat, wmask, sync_x, hist_x, rdata;
  logic [4:0]       sel_r;
  logic [NIO-1:0]   out_r, oeb_r, sync1, sync2, hist;
  logic [CNT_W-1:0] cnt, cnt_nxt, thr;
  logic             unused_adr;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [31:0] m);
    return (old & ~m) | (d & m);
  endfunction

  assign unused_adr = &{1'b0, wbs_adr_i[1:0]};
  assign hit   = wbs_adr_i[31:8] == BASE_ADR[31:8];
  assign req   = wbs_cyc_i & wbs_stb_i & hit & ~ack;
  // A write commits at the end of its ack cycle, and only if the master still holds cyc.
  assign wr    = ack & pnd_we & wbs_cyc_i;
  assign wmask = {{8{pnd_sel[3]}}, {8{pnd_sel[2]}}, {8{pnd_sel[1]}}, {8{pnd_sel[0]}}};
  assign clr   = wr && pnd_off == 6'h00 && pnd_sel[0] && pnd_dat[2];
  assign w1c   = wr && pnd_off == 6'h06 && pnd_sel[0] && pnd_dat[0];

  // Widening to 32 bits makes any SEL beyond the GPIO range read a constant 0.
  always_comb begin
    sync_x = '0;
    hist_x = '0;
    sync_x[NIO-1:0] = sync2;
    hist_x[NIO-1:0] = hist;
  end
  assign edge_det = sync_x[sel_r] & ~hist_x[sel_r];

  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (en && edge_det && cnt != CNT_MAX)
      cnt_nxt = cnt + CNT_W'(1);
  end

  // Pending is raised by the count arriving at THR, not by it resting there.
  assign pend_set = irq_en && thr != '0 && cnt_nxt == thr && cnt_nxt != cnt;

  always_comb begin
    rdata = '0;
    case (pnd_off)
      6'h00:   rdata = {19'b0, sel_r, 6'b0, irq_en, en};
      6'h01:   rdata[NIO-1:0] = out_r;
      6'h02:   rdata[NIO-1:0] = oeb_r;
      6'h03:   rdata[NIO-1:0] = sync2;
      6'h04:   rdata[CNT_W-1:0] = cnt;
      6'h05:   rdata[CNT_W-1:0] = thr;
      6'h06:   rdata[0] = pend;
      default: rdata = '0;
    endcase
  end

  assign wbs_ack_o = ack;
  assign wbs_dat_o = ack ? rdata : '0;
  assign io_out    = out_r;
  assign io_oeb    = oeb_r;
  assign irq       = {2'b00, pend};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack     <= 1'b0;
      pnd_we  <= 1'b0;
      pnd_off <= '0;
      pnd_sel <= '0;
      pnd_dat <= '0;
      sync1   <= '0;
      sync2   <= '0;
      hist    <= '0;
      cnt     <= '0;
      thr     <= '0;
      pend    <= 1'b0;
      en      <= 1'b0;
      irq_en  <= 1'b0;
      sel_r   <= '0;
      out_r   <= '0;
      oeb_r   <= '1;
    end else begin
      ack <= req;
      if (req) begin
        pnd_we  <= wbs_we_i;
        pnd_off <= wbs_adr_i[7:2];
        pnd_sel <= wbs_sel_i;
        pnd_dat <= wbs_dat_i;
      end
      sync1 <= io_in;
      sync2 <= sync1;
      hist  <= sync2;
      cnt   <= cnt_nxt;
      pend  <= pend_set | (pend & ~w1c);
      if (wr) begin
        case (pnd_off)
          6'h00: begin
            if (pnd_sel[0]) begin
              en     <= pnd_dat[0];
              irq_en <= pnd_dat[1];
            end
            if (pnd_sel[1]) sel_r <= pnd_dat[12:8];
          end
          6'h01:   out_r <= NIO'(merge(32'(out_r), pnd_dat, wmask));
          6'h02:   oeb_r <= NIO'(merge(32'(oeb_r), pnd_dat, wmask));
          6'h05:   thr   <= CNT_W'(merge(32'(thr), pnd_dat, wmask));
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_wb_analog_ctrl.sv
// Bench for wb_analog_ctrl: a 16-bit and a 4-bit counter instance share one bus
// and are checked against a register/count model kept here.
module tb_wb_analog_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int NIO = 27;

  logic clk = 1'b0, rst = 1'b1;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0] sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic [NIO-1:0] io_in = '0;
  logic ack_a, ack_b;
  logic [31:0] dat_a, dat_b;
  logic [NIO-1:0] out_a, out_b, oeb_a, oeb_b;
  logic [2:0] irq_a, irq_b;

  int checks = 0, errors = 0;

  logic [31:0] ctrl_m = '0, out_m = '0, oeb_m = 32'h07FF_FFFF;
  int unsigned thr_m = 0, cnt16 = 0, cnt4 = 0;
  bit pend16 = 0, pend4 = 0;

  always #5 clk = ~clk;

  wb_analog_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_a), .wbs_dat_o(dat_a),
    .io_in(io_in), .io_out(out_a), .io_oeb(oeb_a), .irq(irq_a));

  wb_analog_ctrl #(.CNT_W(4)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_b), .wbs_dat_o(dat_b),
    .io_in(io_in), .io_out(out_b), .io_oeb(oeb_b), .irq(irq_b));

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [7:0] off, input bit narrow);
    case (off)
      8'h00:   return ctrl_m;
      8'h04:   return out_m;
      8'h08:   return oeb_m;
      8'h0C:   return 32'(io_in);
      8'h10:   return narrow ? cnt4 : cnt16;
      8'h14:   return narrow ? (thr_m & 15) : thr_m;
      8'h18:   return narrow ? 32'(pend4) : 32'(pend16);
      default: return 32'h0;
    endcase
  endfunction

  task automatic apply_model(input logic [7:0] off, input logic [3:0] s, input logic [31:0] d);
    case (off)
      8'h00: begin
        ctrl_m = merge(ctrl_m, d, s) & 32'h0000_1F03;
        if (s[0] && d[2]) begin cnt16 = 0; cnt4 = 0; end
      end
      8'h04: out_m = merge(out_m, d, s) & 32'h07FF_FFFF;
      8'h08: oeb_m = merge(oeb_m, d, s) & 32'h07FF_FFFF;
      8'h14: thr_m = merge(thr_m, d, s) & 32'h0000_FFFF;
      8'h18: if (s[0] && d[0]) begin pend16 = 0; pend4 = 0; end
      default: ;
    endcase
  endtask

  // One counted rising edge on the selected input, for both counter widths.
  task automatic model_edge();
    int unsigned p;
    p = cnt16;
    if (cnt16 < 65535) cnt16++;
    if (cnt16 != p && cnt16 == thr_m && ctrl_m[1] && thr_m != 0) pend16 = 1;
    p = cnt4;
    if (cnt4 < 15) cnt4++;
    if (cnt4 != p && cnt4 == (thr_m & 15) && ctrl_m[1] && (thr_m & 15) != 0) pend4 = 1;
  endtask

  // Called just after a clock edge; returns two edges later.
  task automatic bus(input bit w, input logic [7:0] off, input logic [3:0] s,
                     input logic [31:0] d, input bit drop_cyc,
                     output logic [31:0] ra, output logic [31:0] rb);
    adr = BASE + 32'(off); we = w; sel = s; wdat = d; cyc = 1; stb = 1;
    tick();
    chk("ack_a", 32'(ack_a), 1);
    chk("ack_b", 32'(ack_b), 1);
    ra = dat_a; rb = dat_b;
    if (drop_cyc) begin cyc = 0; stb = 0; end
    tick();
    cyc = 0; stb = 0; we = 0;
    chk("ack_single", 32'(ack_a), 0);
    chk("dat_idle", dat_a, 0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] ra, rb;
    bus(1, off, s, d, 0, ra, rb);
    apply_model(off, s, d);
  endtask

  task automatic rd(input string tag, input logic [7:0] off);
    logic [31:0] ra, rb;
    bus(0, off, 4'hF, 32'h0, 0, ra, rb);
    chk({tag, "_16"}, ra, exp_rd(off, 0));
    chk({tag, "_4"}, rb, exp_rd(off, 1));
  endtask

  task automatic pulse(input int b);
    io_in[b] = 1'b1;
    tick(2);
    io_in[b] = 1'b0;
    tick(2);
    if (b == int'(ctrl_m[12:8]) && ctrl_m[0]) model_edge();
  endtask

  task automatic chk_state(input string tag);
    rd({tag, "_cnt"}, 8'h10);
    rd({tag, "_stat"}, 8'h18);
    chk({tag, "_irq16"}, 32'(irq_a), {31'b0, pend16});
    chk({tag, "_irq4"}, 32'(irq_b), {31'b0, pend4});
  endtask

  initial begin
    logic [31:0] r, ra, rb;
    logic [7:0] offs [4] = '{8'h00, 8'h04, 8'h08, 8'h14};
    int s, b, n;
    logic [NIO-1:0] bg;

    tick(2);
    chk("rst_oeb", 32'(oeb_a), 32'h07FF_FFFF);
    chk("rst_out", 32'(out_a), 0);
    chk("rst_ack", 32'(ack_a), 0);
    chk("rst_irq", 32'(irq_a), 0);
    rst = 0;
    rd("rst_cnt", 8'h10);
    rd("rst_oeb_rd", 8'h08);

    r = $urandom;
    io_in = r[NIO-1:0];
    tick(3);
    rd("in_sync", 8'h0C);
    io_in = '0;
    tick(3);

    wr(8'h04, 4'b0011, 32'h0555_AAAA);
    chk("out_lanes", 32'(out_a), 32'h0000_AAAA);
    rd("out_rd", 8'h04);

    for (int i = 0; i < 10; i++) begin
      wr(offs[$urandom_range(0, 3)], 4'($urandom), $urandom);
      chk("rnd_out", 32'(out_a), out_m);
      chk("rnd_oeb", 32'(oeb_b), oeb_m);
      rd("rnd_ctrl", 8'h00);
      rd("rnd_thr", 8'h14);
    end

    rd("hole_1c", 8'h1C);
    rd("hole_fc", 8'hFC);
    adr = BASE + 32'h100; cyc = 1; stb = 1; we = 0; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_ack_outside", 32'(ack_a | ack_b), 0);
    end
    cyc = 0; stb = 0;
    tick();

    bus(1, 8'h04, 4'hF, ~out_m, 1, ra, rb);
    chk("cyc_drop_out", 32'(out_a), out_m);

    wr(8'h14, 4'hF, 32'd3);
    wr(8'h00, 4'hF, 32'h0000_0507);
    wr(8'h18, 4'hF, 32'h1);
    pulse(5);
    pulse(5);
    io_in[5] = 1'b1;
    tick(2);
    chk("irq_early", 32'(irq_a), 0);
    tick(1);
    chk("irq_at_3", 32'(irq_a), 1);
    io_in[5] = 1'b0;
    tick(1);
    model_edge();
    chk_state("cnt3");

    io_in[5] = 1'b1;
    tick(1);
    wr(8'h00, 4'hF, 32'h0000_0507);
    io_in[5] = 1'b0;
    tick(2);
    chk_state("clr_race");

    wr(8'h14, 4'hF, 32'd1);
    io_in[5] = 1'b1;
    tick(1);
    wr(8'h18, 4'hF, 32'h1);
    model_edge();
    io_in[5] = 1'b0;
    tick(2);
    chk_state("w1c_race");
    wr(8'h18, 4'hF, 32'h1);
    chk_state("w1c_plain");

    wr(8'h14, 4'hF, 32'd10);
    wr(8'h00, 4'hF, 32'h0000_0507);
    wr(8'h18, 4'hF, 32'h1);
    for (int i = 0; i < 20; i++) pulse(5);
    chk("sat_cnt4", cnt4, 15);
    chk_state("sat20");
    wr(8'h18, 4'hF, 32'h1);
    pulse(5);
    pulse(5);
    chk_state("sat_no_rearm");

    for (int it = 0; it < 8; it++) begin
      wr(8'h00, 4'hF, 32'h0);
      s = $urandom_range(0, 31);
      r = $urandom;
      bg = r[NIO-1:0];
      if (s < NIO) bg[s] = 1'b0;
      io_in = bg;
      tick(4);
      wr(8'h14, 4'hF, 32'($urandom_range(0, 25)));
      wr(8'h00, 4'hF, 32'((s << 8) | 4 | ($urandom_range(0, 1) << 1) | $urandom_range(0, 1)));
      wr(8'h18, 4'hF, 32'h1);
      n = $urandom_range(0, 20);
      b = (s < NIO) ? s : $urandom_range(0, NIO - 1);
      for (int k = 0; k < n; k++) pulse(b);
      tick(1);
      chk_state("rnd_count");
    end

    adr = BASE; cyc = 1; stb = 1; we = 0; sel = 4'hF;
    tick();
    chk("mid_ack", 32'(ack_a), 1);
    rst = 1;
    tick();
    chk("mid_rst_ack", 32'(ack_a), 0);
    chk("mid_rst_oeb", 32'(oeb_a), 32'h07FF_FFFF);
    chk("mid_rst_out", 32'(out_a), 0);
    chk("mid_rst_irq", 32'(irq_b), 0);
    cyc = 0; stb = 0; rst = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
